imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader.sv | 117 +++++++++++
 tb/tb_imem_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Instruction-memory loader shared types and sizes.
// State encoding plus memory geometry used by imem_loader.
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_AW    = 8;
  localparam int WORD_W     = 32;
  localparam int CNT_W      = IMEM_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_DONE
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, zero-fills the rest,
// then raises start_o. Ports: clk_i/rst_i (async low), load_i,
// data_i/valid_i/last_i/ready_o beat stream, mem_we_o/mem_addr_o/
// mem_data_o write port, start_o, busy_o, count_o, overflow_o.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic              ready_o,
  output logic              mem_we_o,
  output logic [IMEM_AW-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_data_o,
  output logic              start_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(IMEM_DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t state_q, state_n;

  // Fill pointer is one bit wider so reaching FULL marks
  // "address 255 already written" without wrapping to 0.
  logic [CNT_W-1:0]   ptr_q, ptr_n;
  logic [CNT_W-1:0]   cnt_n, cnt_inc;
  logic               ovf_n, we_n;
  logic [IMEM_AW-1:0] addr_n;
  logic [WORD_W-1:0]  data_n;

  assign cnt_inc = count_o + ONE;

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    cnt_n   = count_o;
    ovf_n   = overflow_o;
    we_n    = 1'b0;
    addr_n  = mem_addr_o;
    data_n  = mem_data_o;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (load_i) begin
          state_n = S_LOAD;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      S_LOAD: begin
        if (valid_i && ready_o) begin
          if (count_o == FULL) begin
            // Memory full: beat is consumed but discarded.
            ovf_n = 1'b1;
            if (last_i) state_n = S_DONE;
          end else begin
            we_n   = 1'b1;
            addr_n = count_o[IMEM_AW-1:0];
            data_n = data_i;
            cnt_n  = cnt_inc;
            if (last_i) begin
              if (cnt_inc < FULL) begin
                state_n = S_FILL;
                ptr_n   = cnt_inc;
              end else begin
                state_n = S_DONE;
              end
            end
          end
        end
      end
      S_FILL: begin
        if (ptr_q == FULL) begin
          state_n = S_DONE;
        end else begin
          we_n   = 1'b1;
          addr_n = ptr_q[IMEM_AW-1:0];
          data_n = '0;
          ptr_n  = ptr_q + ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      ready_o    <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      start_o    <= 1'b0;
      busy_o     <= 1'b0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      state_q    <= state_n;
      ptr_q      <= ptr_n;
      ready_o    <= (state_n == S_LOAD);
      mem_we_o   <= we_n;
      mem_addr_o <= addr_n;
      mem_data_o <= data_n;
      start_o    <= (state_n == S_DONE);
      busy_o     <= (state_n == S_LOAD) || (state_n == S_FILL);
      count_o    <= cnt_n;
      overflow_o <= ovf_n;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write-capturing
// memory model and hand-computed expectations.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        load_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic        ready_o, mem_we_o, start_o, busy_o, overflow_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic [8:0]  count_o;

  imem_loader dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_i),
    .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .start_o(start_o), .busy_o(busy_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] mem [256];
  int          nwr;
  logic        clr = 1'b0;

  always @(negedge clk_i) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD_BEEF;
      nwr <= 0;
    end else if (mem_we_o) begin
      mem[mem_addr_o] <= mem_data_o;
      nwr <= nwr + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [8:0] exp_cnt;
  logic [31:0] prog [3];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_load();
    clr = 1'b1;
    load_i = 1'b1;
    step();
    clr = 1'b0;
    load_i = 1'b0;
    exp_cnt = '0;
    chk("load_st", {ready_o, busy_o, start_o, count_o, overflow_o},
        {1'b1, 1'b1, 1'b0, 9'd0, 1'b0});
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    valid_i = 1'b1;
    data_i = d;
    last_i = l;
    step();
    valid_i = 1'b0;
    last_i = 1'b0;
    if (exp_cnt < 9'd256) begin
      chk("wr", {mem_we_o, mem_addr_o, mem_data_o},
          {1'b1, exp_cnt[7:0], d});
      exp_cnt = exp_cnt + 9'd1;
    end else begin
      chk("drop", {mem_we_o, overflow_o}, 2'b01);
    end
    chk("cnt", count_o, exp_cnt);
  endtask

  task automatic gap(input logic ld);
    load_i = ld;
    step();
    load_i = 1'b0;
    chk("gap", {mem_we_o, ready_o, busy_o, count_o},
        {1'b0, 1'b1, 1'b1, exp_cnt});
  endtask

  task automatic expect_fill(input int from);
    for (int a = from; a < 256; a++) begin
      step();
      chk("fill", {mem_we_o, mem_addr_o, mem_data_o},
          {1'b1, 8'(a), 32'h0});
    end
    step();
    chk("done", {start_o, busy_o, ready_o, mem_we_o, count_o},
        {4'b1000, exp_cnt});
  endtask

  task automatic check_prog_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ((i < 3) ? prog[i] : 32'h0)) bad++;
    chk(tag, bad, 0);
    chk("nwr", nwr, 256);
  endtask

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3;

    step();
    chk("rst_outs", {ready_o, mem_we_o, mem_addr_o, mem_data_o,
        start_o, busy_o, count_o, overflow_o}, 64'h0);
    rst_i = 1'b1;
    step();
    chk("idle", {ready_o, busy_o, start_o, mem_we_o}, 4'b0000);

    // back-to-back three-word program
    do_load();
    send(prog[0], 1'b0);
    send(prog[1], 1'b0);
    send(prog[2], 1'b1);
    expect_fill(3);
    check_prog_mem("mem_b2b");

    // reload from DONE
    load_i = 1'b1;
    clr = 1'b1;
    step();
    load_i = 1'b0;
    clr = 1'b0;
    exp_cnt = '0;
    chk("reload", {start_o, ready_o, count_o, overflow_o},
        {1'b0, 1'b1, 9'd0, 1'b0});

    // same program with gaps; load_i in LOAD is ignored
    send(prog[0], 1'b0);
    gap(1'b1);
    gap(1'b0);
    send(prog[1], 1'b0);
    gap(1'b0);
    gap(1'b0);
    send(prog[2], 1'b1);
    expect_fill(3);
    check_prog_mem("mem_gap");

    // exactly full program: no fill phase
    do_load();
    for (int i = 0; i < 256; i++)
      send(32'h1000_0000 + 32'(i), i == 255);
    chk("full_start", start_o, 1'b1);
    step();
    chk("full_done", {mem_we_o, start_o, busy_o, count_o, overflow_o},
        {3'b010, 9'd256, 1'b0});
    chk("full_nwr", nwr, 256);
    chk("full_m7", mem[7], 32'h1000_0007);

    // one word too many: dropped, overflow flagged
    do_load();
    for (int i = 0; i < 257; i++)
      send(32'h2000_0000 + 32'(i), i == 256);
    chk("ovf_st", {start_o, busy_o, overflow_o, count_o},
        {3'b101, 9'd256});
    step();
    chk("ovf_hold", {mem_we_o, overflow_o, start_o}, 3'b011);
    chk("ovf_nwr", nwr, 256);
    chk("ovf_m255", mem[255], 32'h2000_00FF);

    // reset while filling at address 100
    do_load();
    send(prog[0], 1'b1);
    for (int a = 1; a <= 100; a++) begin
      step();
      chk("pfill", mem_addr_o, 8'(a));
    end
    #1 rst_i = 1'b0;
    #1;
    chk("rst_mid", {ready_o, mem_we_o, mem_addr_o, mem_data_o,
        start_o, busy_o, count_o, overflow_o}, 64'h0);
    step();
    rst_i = 1'b1;
    step();
    chk("rst_idle", {ready_o, busy_o, start_o, mem_we_o}, 4'b0000);
    do_load();
    send(prog[0], 1'b1);
    expect_fill(1);
    chk("rst_m0", mem[0], prog[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
